// File: rtl/vector_pkg.sv
// Shared definitions for the vector display path: RAM word layout, scan FSM states
// and default geometry. Also imported by the frame writer (memory_manage).
package vector_pkg;

    localparam int unsigned VEC_OUT_WIDTH = 10;
    localparam int unsigned VEC_ADR_WIDTH = 12;

    // RAM word layout, LSB first: beam_en, eof, y, x
    localparam int unsigned BEAM_BIT = 0;
    localparam int unsigned EOF_BIT  = 1;
    localparam int unsigned Y_LSB    = 2;

    function automatic int unsigned x_lsb(input int unsigned out_width);
        return out_width + 2;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_LATCH    = 3'd2,
        ST_DWELL    = 3'd3,
        ST_ENDFRAME = 3'd4
    } scan_state_e;

endpackage

// File: rtl/dwell_timer.sv
// Down-counter that holds a point on the DACs: load on LATCH, count during DWELL,
// expire is high in the final dwell cycle.
module dwell_timer #(
    parameter int unsigned DWELL = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic count,
    output logic expire
);

    localparam logic [7:0] LOAD_VAL = 8'(DWELL - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (count && (cnt_q != 8'd0)) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = count && (cnt_q == 8'd0);

endmodule

// File: rtl/vector_scan.sv
// Double-buffered vector scanner: walks the displayed RAM bank point by point,
// holds each point on the DACs for DWELL cycles and swaps banks at frame end.
module vector_scan
    import vector_pkg::*;
#(
    parameter int unsigned ADR_WIDTH = VEC_ADR_WIDTH,
    parameter int unsigned OUT_WIDTH = VEC_OUT_WIDTH,
    parameter int unsigned DATAWIDTH = 2 * OUT_WIDTH + 2,
    parameter int unsigned DWELL     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [ADR_WIDTH-1:0] adrREAD,
    input  logic [DATAWIDTH-1:0] dataREAD,
    input  logic                 frame_valid,
    output logic                 frame_ack,
    output logic                 bank_read,
    output logic [OUT_WIDTH-1:0] xdac,
    output logic [OUT_WIDTH-1:0] ydac,
    output logic                 beam,
    output logic                 frame_done,
    output logic [2:0]           state_debug
);

    localparam int unsigned PTR_W = ADR_WIDTH - 1;
    localparam int unsigned X_LSB = x_lsb(OUT_WIDTH);

    scan_state_e          state_q, state_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic                 bank_q, bank_d;
    logic [OUT_WIDTH-1:0] x_q, x_d;
    logic [OUT_WIDTH-1:0] y_q, y_d;
    logic                 beam_q, beam_d;
    logic                 eof_q, eof_d;

    logic timer_load;
    logic timer_count;
    logic timer_expire;

    dwell_timer #(
        .DWELL(DWELL)
    ) u_dwell (
        .clk   (clk),
        .rst_n (rst),
        .load  (timer_load),
        .count (timer_count),
        .expire(timer_expire)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        bank_d      = bank_q;
        x_d         = x_q;
        y_d         = y_q;
        beam_d      = beam_q;
        eof_d       = eof_q;
        timer_load  = 1'b0;
        timer_count = 1'b0;
        frame_done  = 1'b0;
        frame_ack   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                state_d = ST_LATCH;
            end
            ST_LATCH: begin
                x_d        = dataREAD[X_LSB +: OUT_WIDTH];
                y_d        = dataREAD[Y_LSB +: OUT_WIDTH];
                eof_d      = dataREAD[EOF_BIT];
                beam_d     = dataREAD[BEAM_BIT];
                timer_load = 1'b1;
                state_d    = ST_DWELL;
            end
            ST_DWELL: begin
                timer_count = 1'b1;
                if (timer_expire) begin
                    if (eof_q || (&ptr_q)) begin
                        state_d = ST_ENDFRAME;
                    end else begin
                        ptr_d   = ptr_q + 1'b1;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_ENDFRAME: begin
                frame_done = 1'b1;
                ptr_d      = '0;
                // Blank the held beam so the new bank's first point stays dark until it latches
                if (frame_valid) begin
                    bank_d    = ~bank_q;
                    frame_ack = 1'b1;
                    beam_d    = 1'b0;
                end
                state_d = ST_FETCH;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            bank_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            beam_q  <= 1'b0;
            eof_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            bank_q  <= bank_d;
            x_q     <= x_d;
            y_q     <= y_d;
            beam_q  <= beam_d;
            eof_q   <= eof_d;
        end
    end

    assign adrREAD     = {bank_q, ptr_q};
    assign bank_read   = bank_q;
    assign xdac        = x_q;
    assign ydac        = y_q;
    assign beam        = beam_q & (state_q != ST_ENDFRAME);
    assign state_debug = state_q;

endmodule

// File: tb/tb_vector_scan.sv
// Self-checking bench for vector_scan: synchronous RAM model plus a frame-level
// reference model (points * (DWELL+2) + 1 cycles, bank bookkeeping, held DAC values).
module tb_vector_scan;

    localparam int AW = 12;
    localparam int OW = 10;
    localparam int DW = 2 * OW + 2;
    localparam int D  = 4;
    localparam int P  = D + 2;
    localparam int BANK_WORDS = 1 << (AW - 1);

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] adrREAD;
    logic [DW-1:0] dataREAD;
    logic          frame_valid;
    logic          frame_ack;
    logic          bank_read;
    logic [OW-1:0] xdac;
    logic [OW-1:0] ydac;
    logic          beam;
    logic          frame_done;
    logic [2:0]    state_debug;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int n_cmp = 0;
    int n_bad = 0;

    logic          m_bank;
    logic [OW-1:0] m_px;
    logic [OW-1:0] m_py;
    logic          m_pb;

    always #5 clk = ~clk;

    always @(posedge clk) dataREAD <= mem[adrREAD];

    vector_scan #(
        .ADR_WIDTH(AW),
        .OUT_WIDTH(OW),
        .DATAWIDTH(DW),
        .DWELL    (D)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .adrREAD    (adrREAD),
        .dataREAD   (dataREAD),
        .frame_valid(frame_valid),
        .frame_ack  (frame_ack),
        .bank_read  (bank_read),
        .xdac       (xdac),
        .ydac       (ydac),
        .beam       (beam),
        .frame_done (frame_done),
        .state_debug(state_debug)
    );

    function automatic logic [DW-1:0] mk(input int unsigned x, input int unsigned y,
                                         input bit eof, input bit b);
        return {OW'(x), OW'(y), eof, b};
    endfunction

    function automatic int frame_len(input logic bank);
        logic [AW-1:0] a;
        for (int i = 0; i < BANK_WORDS; i++) begin
            a = {bank, (AW-1)'(i)};
            if (mem[a][1]) return i + 1;
        end
        return BANK_WORDS;
    endfunction

    task automatic do_start();
        frame_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        m_bank = 1'b0;
        m_px = '0;
        m_py = '0;
        m_pb = 1'b0;
    endtask

    task automatic fill_random_short();
        int eofpos;
        for (int b = 0; b < 2; b++) begin
            eofpos = $urandom_range(0, 5);
            for (int j = 0; j < 8; j++)
                mem[{b[0], (AW-1)'(j)}] = mk($urandom, $urandom, (j == eofpos), 1'($urandom));
        end
    endtask

    // Steps one whole frame from its first FETCH to its ENDFRAME, checking every cycle.
    task automatic play_frame(input bit fv, input string tag, output int acks);
        int n, total, i, ph;
        logic [DW-1:0]     w;
        logic [AW-1:0]     exp_adr;
        logic [2*OW+3:0]   got, expv;
        n = frame_len(m_bank);
        total = n * P + 1;
        acks = 0;
        for (int k = 0; k < total; k++) begin
            @(negedge clk);
            if (k == 0) frame_valid = fv;
            if (frame_ack === 1'b1) acks++;
            got = {frame_done, frame_ack, bank_read, xdac, ydac, beam};
            if (k == total - 1) begin
                expv = {1'b1, fv, m_bank, m_px, m_py, 1'b0};
            end else begin
                i  = k / P;
                ph = k % P;
                w  = mem[{m_bank, (AW-1)'(i)}];
                if (ph == 2) begin
                    m_px = w[DW-1 -: OW];
                    m_py = w[OW+1 -: OW];
                    m_pb = w[0];
                end
                if (ph == 0) begin
                    exp_adr = {m_bank, (AW-1)'(i)};
                    n_cmp++;
                    if (adrREAD !== exp_adr) begin
                        n_bad++;
                        $display("FAIL %s adr point %0d: got %h expected %h", tag, i, adrREAD, exp_adr);
                    end
                end
                expv = {2'b00, m_bank, m_px, m_py, m_pb};
            end
            n_cmp++;
            if (got !== expv) begin
                n_bad++;
                $display("FAIL %s cycle %0d {done,ack,bank,x,y,beam}: got %h expected %h",
                         tag, k, got, expv);
            end
        end
        if (fv) begin
            m_bank = ~m_bank;
            m_pb = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [AW+2*OW+6:0] got;
        #1;
        got = {adrREAD, xdac, ydac, beam, frame_ack, frame_done, bank_read, state_debug};
        n_cmp++;
        if (got !== '0) begin
            n_bad++;
            $display("FAIL reset_initial: got %h expected 0", got);
        end
        repeat (3) @(negedge clk);
        got = {adrREAD, xdac, ydac, beam, frame_ack, frame_done, bank_read, state_debug};
        n_cmp++;
        if (got !== '0) begin
            n_bad++;
            $display("FAIL reset_held: got %h expected 0", got);
        end
    endtask

    task automatic test_two_point();
        int acks;
        mem[0] = mk(100, 120, 1'b0, 1'b1);
        mem[1] = mk(200, 53, 1'b1, 1'b1);
        do_start();
        play_frame(1'b0, "two_point", acks);
        n_cmp++;
        if (acks !== 0) begin
            n_bad++;
            $display("FAIL two_point_ack: got %0d acks expected 0", acks);
        end
    endtask

    task automatic test_replay();
        int acks;
        play_frame(1'b0, "replay", acks);
        n_cmp++;
        if (acks !== 0) begin
            n_bad++;
            $display("FAIL replay_ack: got %0d acks expected 0", acks);
        end
    endtask

    task automatic test_swap();
        int acks;
        mem[12'h800] = mk(300, 400, 1'b0, 1'b1);
        mem[12'h801] = mk(5, 6, 1'b0, 1'b0);
        mem[12'h802] = mk(1023, 0, 1'b1, 1'b1);
        play_frame(1'b1, "swap", acks);
        n_cmp++;
        if (acks !== 1) begin
            n_bad++;
            $display("FAIL swap_ack: got %0d acks expected 1", acks);
        end
        play_frame(1'b0, "after_swap", acks);
        n_cmp++;
        if (acks !== 0) begin
            n_bad++;
            $display("FAIL after_swap_ack: got %0d acks expected 0", acks);
        end
    endtask

    task automatic test_random_frames();
        int acks;
        bit fv;
        fill_random_short();
        do_start();
        for (int f = 0; f < 8; f++) begin
            fv = 1'($urandom_range(0, 1));
            play_frame(fv, "random", acks);
            n_cmp++;
            if (acks !== int'(fv)) begin
                n_bad++;
                $display("FAIL random_ack frame %0d: got %0d expected %0d", f, acks, fv);
            end
        end
    endtask

    task automatic test_no_eof();
        int acks;
        for (int i = 0; i < BANK_WORDS; i++)
            mem[i] = mk($urandom, $urandom, 1'b0, 1'($urandom));
        do_start();
        play_frame(1'b0, "no_eof", acks);
        @(negedge clk);
        n_cmp++;
        if (adrREAD !== '0) begin
            n_bad++;
            $display("FAIL no_eof_wrap: adr got %h expected 000", adrREAD);
        end
    endtask

    task automatic test_reset_mid_dwell();
        int acks;
        logic [AW+2*OW+6:0] got;
        mem[0] = mk(100, 120, 1'b0, 1'b1);
        mem[1] = mk(200, 53, 1'b1, 1'b1);
        do_start();
        repeat (4) @(negedge clk);
        n_cmp++;
        if ({xdac, ydac, beam} !== {10'd100, 10'd120, 1'b1}) begin
            n_bad++;
            $display("FAIL mid_dwell_pre: got %h expected %h", {xdac, ydac, beam},
                     {10'd100, 10'd120, 1'b1});
        end
        #2 rst = 1'b0;
        #1;
        got = {adrREAD, xdac, ydac, beam, frame_ack, frame_done, bank_read, state_debug};
        n_cmp++;
        if (got !== '0) begin
            n_bad++;
            $display("FAIL mid_dwell_async_reset: got %h expected 0", got);
        end
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if ({frame_done, frame_ack} !== 2'b00) begin
                n_bad++;
                $display("FAIL mid_dwell_pulses: got %b expected 00", {frame_done, frame_ack});
            end
        end
        rst = 1'b1;
        m_bank = 1'b0;
        m_px = '0;
        m_py = '0;
        m_pb = 1'b0;
        play_frame(1'b0, "post_reset", acks);
    endtask

    task automatic test_back_to_back();
        int acks;
        int total_acks;
        fill_random_short();
        do_start();
        total_acks = 0;
        for (int f = 0; f < 4; f++) begin
            play_frame(1'b1, "back_to_back", acks);
            total_acks += acks;
        end
        @(negedge clk);
        frame_valid = 1'b0;
        n_cmp++;
        if (total_acks !== 4) begin
            n_bad++;
            $display("FAIL back_to_back_acks: got %0d expected 4", total_acks);
        end
        n_cmp++;
        if ({bank_read, adrREAD} !== {1'b0, 12'h000}) begin
            n_bad++;
            $display("FAIL back_to_back_bank: got %b/%h expected 0/000", bank_read, adrREAD);
        end
    endtask

    initial begin
        rst = 1'b0;
        frame_valid = 1'b0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        test_reset();
        test_two_point();
        test_replay();
        test_swap();
        test_random_frames();
        test_no_eof();
        test_reset_mid_dwell();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
